// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Bridges single CPU load/store requests onto a word-wide data memory with a
//   registered (1-cycle latency) read port. Handles byte/halfword/word access
//   with big-endian lane selection, sign/zero extension on loads, and
//   read-modify-write for sub-word stores. Misaligned or illegal-size requests
//   complete immediately with err=1 and never touch memory.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   req              CPU request, inputs held stable until done
//   we               1 = store, 0 = load
//   size             00 byte, 01 halfword, 10 word, 11 illegal
//   sgn              sign-extend byte/half loads
//   addr             byte address
//   wdata            store data, right-justified for byte/half
//   rdata            load result (held between accesses)
//   done             one-cycle completion pulse
//   stall            pipeline hold = req & ~done
//   err              misalignment / illegal-size flag (held between accesses)
//   memAddr          word-aligned byte address to memory (0 when idle)
//   memWriteData     full word to memory (0 unless writing)
//   MemWrite/MemRead memory strobes, never both high
//   memReadData      memory read data, valid the cycle after MemRead
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        stall,
  output logic        err,
  output logic [31:0] memAddr,
  output logic [31:0] memWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] memReadData
);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

  state_t      state, next;
  logic        we_q, sgn_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, word_q, rdata_q;
  logic        misaligned, accept;

  assign misaligned = (size == 2'b11) ||
                      (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00);
  assign accept     = (state == IDLE) && req;

  // Big-endian lane extract: offset 0 is the most significant byte.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] off, input logic s);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   extract = {{24{s & b[7]}}, b};
      2'b01:   extract = {{16{s & h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  // Replace only the addressed lane; all other bits come from the read word.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz,
                                        input logic [1:0] off, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end else if (sz == 2'b01) begin
      if (off[1]) r[15:0]  = d[15:0];
      else        r[31:16] = d[15:0];
    end
    merge = r;
  endfunction

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        we_q   <= we;
        sgn_q  <= sgn;
        size_q <= size;
        addr_q <= addr;
        word_q <= wdata;       // word stores go straight to WR with this
        err_q  <= misaligned;
      end
      if (state == RD_WAIT) begin
        if (we_q) word_q  <= merge(memReadData, size_q, addr_q[1:0], word_q);
        else      rdata_q <= extract(memReadData, size_q, addr_q[1:0], sgn_q);
      end
    end
  end

  // Strobes and address are decoded from state alone, so reset forces them
  // low asynchronously and an aborted write never reaches memory.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    next         = state;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    memAddr      = '0;
    memWriteData = '0;
    case (state)
      IDLE: begin
        if (req) begin
          if (misaligned)                 next = RESP;
          else if (we && size == 2'b10)   next = WR;
          else                            next = RD;
        end
      end
      RD: begin
        MemRead = 1'b1;
        memAddr = {addr_q[31:2], 2'b00};
        next    = RD_WAIT;
      end
      RD_WAIT: begin
        MemRead = 1'b1;
        memAddr = {addr_q[31:2], 2'b00};
        next    = we_q ? WR : RESP;
      end
      WR: begin
        MemWrite     = 1'b1;
        memAddr      = {addr_q[31:2], 2'b00};
        memWriteData = word_q;
        next         = RESP;
      end
      RESP:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign done  = (state == RESP);
  assign stall = req & ~done;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Randomized scoreboard bench for mem_access_unit. A word-wide data memory
//   with registered read sits behind the DUT; a byte-addressed reference
//   memory computes expected load results, error flags, latencies and strobe
//   counts, which a monitor compares whenever done pulses.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset, req, we, sgn;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, memAddr, memWriteData, memReadData;
  logic        done, stall, err, MemWrite, MemRead;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sgn(sgn),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .stall(stall),
    .err(err), .memAddr(memAddr), .memWriteData(memWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  // Data memory: 64 words, registered read returning zero unless MemRead.
  logic [31:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;
  always @(posedge clk) begin
    if (pl_en)    mem[pl_idx] <= pl_data;
    if (MemWrite) mem[memAddr[7:2]] <= memWriteData;
    memReadData <= MemRead ? mem[memAddr[7:2]] : 32'h0;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model: plain byte array, big-endian word layout.
  logic [7:0] ref_mem [256];

  typedef struct {
    string       name;
    logic [31:0] rdata;
    bit          chk_rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_bad = 0;
  int rd_cnt = 0, wr_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input int a, input logic [1:0] sz, input logic s);
    int v;
    case (sz)
      2'b00: begin v = ref_mem[a]; if (s && v > 127) v -= 256; end
      2'b01: begin v = ref_mem[a] * 256 + ref_mem[a+1]; if (s && v > 32767) v -= 65536; end
      default: return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
    endcase
    return 32'(v);
  endfunction

  task automatic preload(input int widx, input logic [31:0] w);
    pl_idx = 6'(widx); pl_data = w; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[4*widx]   = w[31:24];
    ref_mem[4*widx+1] = w[23:16];
    ref_mem[4*widx+2] = w[15:8];
    ref_mem[4*widx+3] = w[7:0];
  endtask

  // Issue one request. b2b=1 drives it while the previous response is still
  // showing, so it must not be accepted until the DUT is back in IDLE.
  task automatic issue(input logic w, input logic [1:0] sz, input logic s,
                       input logic [31:0] a, input logic [31:0] d, input bit b2b,
                       input string nm);
    exp_t e;
    int   ai, k;
    bit   mis;
    if (!b2b) begin @(negedge clk); #1; end
    ai  = int'(a[7:0]);
    mis = (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0);
    e.name = nm; e.chk_rdata = 1'b0; e.rdata = '0; e.err = mis;
    e.acc  = cyc + (b2b ? 2 : 1);
    if (mis)                  begin e.lat = 1; e.nrd = 0; e.nwr = 0; end
    else if (!w)              begin e.lat = 3; e.nrd = 2; e.nwr = 0;
                                    e.rdata = ref_load(ai, sz, s); e.chk_rdata = 1'b1; end
    else if (sz == 2'b10)     begin e.lat = 2; e.nrd = 0; e.nwr = 1; end
    else                      begin e.lat = 4; e.nrd = 2; e.nwr = 1; end
    if (w && !mis) begin
      if (sz == 2'b00) ref_mem[ai] = d[7:0];
      else if (sz == 2'b01) begin ref_mem[ai] = d[15:8]; ref_mem[ai+1] = d[7:0]; end
      else begin
        ref_mem[ai] = d[31:24]; ref_mem[ai+1] = d[23:16];
        ref_mem[ai+2] = d[15:8]; ref_mem[ai+3] = d[7:0];
      end
    end
    exp_q.push_back(e);
    req = 1'b1; we = w; size = sz; sgn = s; addr = a; wdata = d;
    k = 0;
    do begin @(negedge clk); #1; k++; end while (!done && k < 40);
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: no done within %0d cycles", nm, k);
    end
    req = 1'b0;
  endtask

  // Monitor: protocol invariants every cycle, scoreboard pop on done.
  always @(negedge clk) begin
    if (!reset) begin
      check("strobe_excl", {31'b0, MemRead & MemWrite}, 32'h0);
      check("stall", {31'b0, stall}, {31'b0, req & ~done});
      rd_cnt += int'(MemRead);
      wr_cnt += int'(MemWrite);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending request");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_err"}, {31'b0, err}, {31'b0, e.err});
          check({e.name, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
          check({e.name, "_nrd"}, 32'(rd_cnt), 32'(e.nrd));
          check({e.name, "_nwr"}, 32'(wr_cnt), 32'(e.nwr));
          if (e.chk_rdata) check({e.name, "_rdata"}, rdata, e.rdata);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  initial begin
    logic [1:0] sz;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sgn = 1'b0;
    addr = '0; wdata = '0;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_strobes", {30'b0, MemRead, MemWrite}, 32'h0);
    check("rst_memAddr", memAddr, 32'h0);
    check("rst_memWriteData", memWriteData, 32'h0);
    @(negedge clk); reset = 1'b0; #1;

    // Directed cases
    preload(16, 32'h12345678);
    issue(1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 1'b0, "lb41");
    preload(4, 32'h80FF0000);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, "lh10s");
    issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b1, "lh10u");
    preload(8, 32'hAABBCCDD);
    issue(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000EE, 1'b0, "sb22");
    check("sb22_mem", mem[8], 32'hAABBEEDD);
    issue(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 1'b0, "sw08");
    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b1, "lw08");
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b0, "lw06_mis");
    issue(1'b1, 2'b01, 1'b0, 32'h03, 32'h1234, 1'b1, "sh03_mis");
    issue(1'b0, 2'b11, 1'b0, 32'h04, 32'h0, 1'b0, "illegal_size");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      issue(1'($urandom), sz, 1'($urandom), 32'($urandom_range(0, 255)),
            $urandom, 1'($urandom), "rnd");
    end

    // Reset during WR of a sub-word store: memory must be left untouched.
    preload(8, 32'hAABBCCDD);
    @(negedge clk); #1;
    req = 1'b1; we = 1'b1; size = 2'b00; sgn = 1'b0; addr = 32'h20; wdata = 32'h55;
    begin
      int k;
      k = 0;
      do begin @(negedge clk); #1; k++; end while (!MemWrite && k < 20);
      check("abort_reached_wr", {31'b0, MemWrite}, 32'h1);
    end
    req = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_MemWrite", {31'b0, MemWrite}, 32'h0);
    check("abort_MemRead", {31'b0, MemRead}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_memAddr", memAddr, 32'h0);
    check("abort_memWriteData", memWriteData, 32'h0);
    check("abort_rdata_err", {rdata[30:0], err}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    rd_cnt = 0; wr_cnt = 0;
    check("abort_mem", mem[8], 32'hAABBCCDD);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, "lw20_after_rst");

    repeat (4) @(negedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < 64; i++)
      check("final_mem", mem[i], {ref_mem[4*i], ref_mem[4*i+1], ref_mem[4*i+2], ref_mem[4*i+3]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
